// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM bank between the comms host port and the compute core.
// The host owns the port whenever its session is active; reads are tagged so data returns to its issuer.
module bram_arbiter #(
    parameter  int unsigned DEPTH        = 49152,
    parameter  int unsigned WIDTH        = 64,
    parameter  int unsigned READ_LATENCY = 2,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,

    input  logic             host_busy_in,
    input  logic [AW-1:0]    host_addr_in,
    input  logic [WIDTH-1:0] host_wdata_in,
    input  logic             host_we_in,
    input  logic             host_re_in,
    output logic [WIDTH-1:0] host_rdata_out,
    output logic             host_rvalid_out,

    input  logic             core_req_in,
    input  logic [AW-1:0]    core_addr_in,
    input  logic [WIDTH-1:0] core_wdata_in,
    input  logic             core_we_in,
    input  logic             core_re_in,
    output logic             core_gnt_out,
    output logic [WIDTH-1:0] core_rdata_out,
    output logic             core_rvalid_out,

    output logic [AW-1:0]    bram_addr_out,
    output logic [WIDTH-1:0] bram_din_out,
    output logic             bram_we_out,
    output logic             bram_en_out,
    input  logic [WIDTH-1:0] bram_dout_in,

    output logic [1:0]       owner_out,
    output logic             conflict_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOST  = 2'd1,
        ST_CORE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Every pipeline stage except the tail; the tail is the cycle whose rvalid is being shown.
    localparam logic [READ_LATENCY-1:0] BODY_MASK = {READ_LATENCY{1'b1}} >> 1;

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [WIDTH-1:0]        din_q, din_d;
    logic                    we_q, we_d;
    logic                    en_q, en_d;
    logic                    gnt_q, gnt_d;
    logic                    conflict_q, conflict_d;
    logic                    iss_h_q, iss_h_d;
    logic                    iss_c_q, iss_c_d;
    logic [READ_LATENCY-1:0] pipe_h_q, pipe_h_d;
    logic [READ_LATENCY-1:0] pipe_c_q, pipe_c_d;

    logic host_strobe;
    logic core_strobe;
    logic host_issue;
    logic core_issue;
    logic pipe_busy;

    assign host_strobe = host_we_in | host_re_in;
    assign core_strobe = core_we_in | core_re_in;
    assign host_issue  = (state_q == ST_HOST) & host_strobe;
    assign core_issue  = (state_q == ST_CORE) & core_strobe;

    // Reads still owed to a requester once the current tail has been delivered.
    assign pipe_busy = iss_h_q | iss_c_q | (|((pipe_h_q | pipe_c_q) & BODY_MASK));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = 1'b0;
        en_d       = 1'b0;
        iss_h_d    = 1'b0;
        iss_c_d    = 1'b0;
        pipe_h_d   = READ_LATENCY'({pipe_h_q, iss_h_q});
        pipe_c_d   = READ_LATENCY'({pipe_c_q, iss_c_q});
        conflict_d = (host_strobe & ~host_issue)
                   | (core_strobe & ~core_issue)
                   | (host_issue & host_we_in & host_re_in)
                   | (core_issue & core_we_in & core_re_in);

        // Only the owner's strobe reaches the BRAM; a write beats a simultaneous read.
        if (host_issue) begin
            en_d    = 1'b1;
            we_d    = host_we_in;
            addr_d  = host_addr_in;
            din_d   = host_wdata_in;
            iss_h_d = ~host_we_in;
        end else if (core_issue) begin
            en_d    = 1'b1;
            we_d    = core_we_in;
            addr_d  = core_addr_in;
            din_d   = core_wdata_in;
            iss_c_d = ~core_we_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (host_busy_in) begin
                    state_d = ST_HOST;
                end else if (core_req_in) begin
                    state_d = ST_CORE;
                end
            end
            ST_HOST: begin
                if (!host_busy_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CORE: begin
                if (host_busy_in || !core_req_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    if (host_busy_in) begin
                        state_d = ST_HOST;
                    end else if (core_req_in) begin
                        state_d = ST_CORE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gnt_d = (state_d == ST_CORE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            en_q       <= 1'b0;
            gnt_q      <= 1'b0;
            conflict_q <= 1'b0;
            iss_h_q    <= 1'b0;
            iss_c_q    <= 1'b0;
            pipe_h_q   <= '0;
            pipe_c_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            en_q       <= en_d;
            gnt_q      <= gnt_d;
            conflict_q <= conflict_d;
            iss_h_q    <= iss_h_d;
            iss_c_q    <= iss_c_d;
            pipe_h_q   <= pipe_h_d;
            pipe_c_q   <= pipe_c_d;
        end
    end

    assign bram_addr_out   = addr_q;
    assign bram_din_out    = din_q;
    assign bram_we_out     = we_q;
    assign bram_en_out     = en_q;
    assign core_gnt_out    = gnt_q;
    assign conflict_out    = conflict_q;
    assign owner_out       = state_q;
    assign host_rdata_out  = bram_dout_in;
    assign core_rdata_out  = bram_dout_in;
    assign host_rvalid_out = pipe_h_q[READ_LATENCY-1];
    assign core_rvalid_out = pipe_c_q[READ_LATENCY-1];

endmodule
